// File: rtl/pipeline_stage_register.sv
// rtl/pipeline_stage_register.sv - DEPTH-deep inter-stage register with valid, stall, flush and async reset.
// Optional PIPE_STAGE_STATS_EN adds saturating bubble_count / stall_count outputs.
module pipeline_stage_register #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 165,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] control_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] control_out,
  output logic [DATA_W-1:0] data_out
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       bubble_count,
  output logic [31:0]       stall_count
`endif
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $error("pipeline_stage_register: DEPTH must be in 1..4");
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              v_q;
    logic [CTRL_W-1:0] c_q;
    logic [DATA_W-1:0] d_q;
    logic              v_src;
    logic [CTRL_W-1:0] c_src;
    logic [DATA_W-1:0] d_src;

    if (k == 0) begin : g_first
      // Bubbles enter with zeroed control so no write enable can ride along.
      assign v_src = valid_in;
      assign c_src = valid_in ? control_in : '0;
      assign d_src = data_in;
    end else begin : g_next
      assign v_src = g_stage[k-1].v_q;
      assign c_src = g_stage[k-1].c_q;
      assign d_src = g_stage[k-1].d_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= '0;
        d_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
        c_q <= '0;
      end else if (!stall) begin
        v_q <= v_src;
        c_q <= c_src;
        d_q <= d_src;
      end
    end
  end

  assign valid_out   = g_stage[DEPTH-1].v_q;
  assign control_out = g_stage[DEPTH-1].c_q;
  assign data_out    = g_stage[DEPTH-1].d_q;

`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
      stall_count  <= '0;
    end else begin
      if (stall && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
      if (!stall && !valid_out && bubble_count != 32'hFFFF_FFFF)
        bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb/tb_pipeline_stage_register.sv - queue-model self-checking bench over DEPTH 1, 2 and 3 instances.
module tb_pipeline_stage_register;
  localparam int CW = 3;
  localparam int DW = 165;
  localparam longint MAXC = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst, stall, flush, vin;
  logic [CW-1:0] cin;
  logic [DW-1:0] din;
  logic v1, v2, v3;
  logic [CW-1:0] c1, c2, c3;
  logic [DW-1:0] d1, d2, d3;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] b1, s1, b2, s2, b3, s3;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_stage_register #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(1)) u1 (
    .clk(clk), .reset(rst), .stall(stall), .flush(flush), .valid_in(vin),
    .control_in(cin), .data_in(din), .valid_out(v1), .control_out(c1), .data_out(d1)
`ifdef PIPE_STAGE_STATS_EN
    , .bubble_count(b1), .stall_count(s1)
`endif
  );

  pipeline_stage_register #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(2)) u2 (
    .clk(clk), .reset(rst), .stall(stall), .flush(flush), .valid_in(vin),
    .control_in(cin), .data_in(din), .valid_out(v2), .control_out(c2), .data_out(d2)
`ifdef PIPE_STAGE_STATS_EN
    , .bubble_count(b2), .stall_count(s2)
`endif
  );

  pipeline_stage_register #(.CTRL_W(CW), .DATA_W(DW), .DEPTH(3)) u3 (
    .clk(clk), .reset(rst), .stall(stall), .flush(flush), .valid_in(vin),
    .control_in(cin), .data_in(din), .valid_out(v3), .control_out(c3), .data_out(d3)
`ifdef PIPE_STAGE_STATS_EN
    , .bubble_count(b3), .stall_count(s3)
`endif
  );

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  typedef ent_t eq_t[$];

  // Model: a queue per pipeline, front = newest entry, back = what the outputs show.
  eq_t m1, m2, m3;
  longint bc, sc;

  function automatic eq_t mk(int n);
    eq_t q;
    for (int i = 0; i < n; i++) q.push_back('0);
    return q;
  endfunction

  function automatic eq_t step(eq_t q);
    ent_t e;
    if (flush) begin
      foreach (q[i]) begin
        q[i].v = 1'b0;
        q[i].c = '0;
      end
    end else if (!stall) begin
      e.v = vin;
      e.c = vin ? cin : '0;
      e.d = din;
      q.push_front(e);
      void'(q.pop_back());
    end
    return q;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input string tag, input ent_t e, input logic v,
                         input logic [CW-1:0] c, input logic [DW-1:0] d);
    chk({tag, "_valid"}, DW'(v), DW'(e.v));
    chk({tag, "_control"}, DW'(c), DW'(e.c));
    if (e.v) chk({tag, "_data"}, d, e.d);
  endtask

  initial begin
    m1 = mk(1); m2 = mk(2); m3 = mk(3); bc = 0; sc = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m1 = mk(1); m2 = mk(2); m3 = mk(3); bc = 0; sc = 0;
      end else begin
        if (stall && sc < MAXC) sc++;
        if (!stall && !m1[0].v && bc < MAXC) bc++;
        m1 = step(m1); m2 = step(m2); m3 = step(m3);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cmp_one("d1", m1[0], v1, c1, d1);
      cmp_one("d2", m2[1], v2, c2, d2);
      cmp_one("d3", m3[2], v3, c3, d3);
`ifdef PIPE_STAGE_STATS_EN
      chk("bubble_count", DW'(b1), DW'(bc));
      chk("stall_count", DW'(s1), DW'(sc));
`endif
    end
  end

  task automatic tick(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic s, input logic f);
    vin = v; cin = c; din = d; stall = s; flush = f;
    @(negedge clk);
  endtask

  logic [2:0] tbl [10];

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; vin = 1'b0; cin = '0; din = '0;
    repeat (2) @(negedge clk);
    chk("reset_v3", DW'(v3), '0);
    rst = 1'b0;

    // Async reset mid-cycle, held across an edge, released between edges
    tick(1'b1, 3'b111, DW'(1), 1'b0, 1'b0);
    chk("t1_pre_valid", DW'(v1), DW'(1));
    chk("t1_pre_control", DW'(c1), DW'(3'b111));
    #2 rst = 1'b1;
    #1 chk("t1_async_valid", DW'(v1), '0);
    chk("t1_async_control", DW'(c1), '0);
    chk("t1_async_data", d1, '0);
    @(negedge clk);
    chk("t1_held_valid", DW'(v1), '0);
    #2 rst = 1'b0;
    #1 chk("t1_released_valid", DW'(v1), '0);
    @(negedge clk);
    chk("t1_capture_valid", DW'(v1), DW'(1));
    chk("t1_capture_control", DW'(c1), DW'(3'b111));

    // DEPTH=3 streaming latency
    for (int i = 1; i <= 6; i++) begin
      tick(i <= 4, CW'(i), DW'(i), 1'b0, 1'b0);
      if (i >= 3) begin
        chk("t2_data", d3, DW'(i - 2));
        chk("t2_valid", DW'(v3), DW'(1));
      end
    end

    // Stall hold on DEPTH=1
    tick(1'b1, 3'b101, DW'('hA5), 1'b0, 1'b0);
    chk("t3_load_data", d1, DW'('hA5));
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 3'b010, DW'('h3C), 1'b1, 1'b0);
      chk("t3_hold_data", d1, DW'('hA5));
      chk("t3_hold_control", DW'(c1), DW'(3'b101));
    end
    tick(1'b1, 3'b010, DW'('h3C), 1'b0, 1'b0);
    chk("t3_resume_data", d1, DW'('h3C));
    chk("t3_resume_control", DW'(c1), DW'(3'b010));

    // Flush with stall on DEPTH=2, both stages valid
    tick(1'b1, 3'b110, DW'('h11), 1'b0, 1'b0);
    tick(1'b1, 3'b011, DW'('h22), 1'b0, 1'b0);
    chk("t4_pre_valid", DW'(v2), DW'(1));
    chk("t4_pre_data", d2, DW'('h11));
    tick(1'b1, 3'b111, DW'('h33), 1'b1, 1'b1);
    chk("t4_flush_valid", DW'(v2), '0);
    chk("t4_flush_control", DW'(c2), '0);
    chk("t4_flush_data_held", d2, DW'('h11));
    tick(1'b1, 3'b111, DW'('h44), 1'b0, 1'b0);
    chk("t4_bubble_valid", DW'(v2), '0);
    chk("t4_bubble_control", DW'(c2), '0);
    chk("t4_bubble_data", d2, DW'('h22));
    tick(1'b1, 3'b001, DW'('h55), 1'b0, 1'b0);
    chk("t4_resume_valid", DW'(v2), DW'(1));
    chk("t4_resume_data", d2, DW'('h44));

    // Invalid input with all control bits set never leaks control
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 3'b111, DW'('h66 + i), 1'b0, 1'b0);
      chk("t5_control_d1", DW'(c1), '0);
      chk("t5_valid_d1", DW'(v1), '0);
    end
    chk("t5_control_d3", DW'(c3), '0);
    chk("t5_data_d1", d1, DW'('h68));

    // Mixed control table: {valid_in, stall, flush}
    tbl[0] = 3'b100; tbl[1] = 3'b110; tbl[2] = 3'b000; tbl[3] = 3'b101;
    tbl[4] = 3'b100; tbl[5] = 3'b111; tbl[6] = 3'b100; tbl[7] = 3'b010;
    tbl[8] = 3'b100; tbl[9] = 3'b100;
    for (int i = 0; i < 10; i++)
      tick(tbl[i][2], CW'(i + 1), DW'('h100 + i), tbl[i][1], tbl[i][0]);

`ifdef PIPE_STAGE_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, '0, '0, 1'b0, 1'b0);
    chk("t6_stall_count", DW'(s1), DW'(3));
    chk("t6_bubble_count", DW'(b1), DW'(2));
    chk("t6_stall_count_d3", DW'(s3), DW'(3));
`endif

    tick(1'b0, '0, '0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
